// File: rtl/demux_8_stream.sv
// 1-to-8 addressed stream demultiplexer with a 2-entry input FIFO.
// Registered-only in_ready, one-hot per-channel valid, and a saturating counter for words offered while deselected.
module demux_8_stream #(
    parameter int width     = 8,
    parameter int cnt_width = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 nCS,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_addr,
    input  logic [width-1:0]     in_data,
    output logic [7:0]           out_valid,
    input  logic [7:0]           out_ready,
    output logic [width-1:0]     out_data,
    output logic [cnt_width-1:0] drop_cnt
);

    logic [1:0][2:0]       addr_q;
    logic [1:0][width-1:0] data_q;
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            count_q, count_d;
    logic [cnt_width-1:0]  drop_cnt_q, drop_cnt_d;

    logic [2:0] head_addr;
    logic       any_vld, push, pop;

    assign head_addr = addr_q[rd_ptr_q];
    assign any_vld   = !nCS && (count_q != 2'd0);

    // in_ready is built from registered state only, so no path from out_ready.
    assign in_ready  = !nCS && (count_q < 2'd2);
    assign push      = in_valid && in_ready;
    assign pop       = any_vld && out_ready[head_addr];

    for (genvar i = 0; i < 8; i++) begin : g_vld
        assign out_valid[i] = any_vld && (head_addr == 3'(i));
    end

    assign out_data = any_vld ? data_q[rd_ptr_q] : '0;
    assign drop_cnt = drop_cnt_q;

    always_comb begin
        count_d    = count_q + 2'(push) - 2'(pop);
        drop_cnt_d = drop_cnt_q;
        if (nCS && in_valid && (drop_cnt_q != '1))
            drop_cnt_d = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            data_q     <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            drop_cnt_q <= '0;
        end else begin
            if (push) begin
                addr_q[wr_ptr_q] <= in_addr;
                data_q[wr_ptr_q] <= in_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_demux_8_stream.sv
// Bench for demux_8_stream: directed vector table, hand-written corner sequences,
// and random traffic checked against a queue-based reference model.
module tb_demux_8_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       nCS, in_valid, in_ready;
    logic [2:0] in_addr;
    logic [7:0] in_data, out_valid, out_ready, out_data, drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    demux_8_stream #(.width(8), .cnt_width(8)) dut (
        .clk(clk), .rst(rst), .nCS(nCS), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ncs, iv;
        logic [2:0] a;
        logic [7:0] d, rdy;
        logic       exp_ir;
        logic [7:0] exp_ov, exp_od;
    } vec_t;

    typedef struct {
        logic [2:0] a;
        logic [7:0] d;
    } word_t;

    vec_t  tbl [12];
    word_t q[$];
    int    drops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic ncs, input logic iv, input logic [2:0] a,
                         input logic [7:0] d, input logic [7:0] rdy);
        nCS = ncs; in_valid = iv; in_addr = a; in_data = d; out_ready = rdy;
    endtask

    task automatic do_reset();
        apply(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h1);
        chk("rst_drop_cnt",  32'(drop_cnt),  32'h0);
        rst = 1'b0;
        q.delete();
        drops = 0;
        @(posedge clk); #1;
    endtask

    // One clock cycle: drive inputs, compare against the queue model, advance the model.
    task automatic cyc(input logic ncs, input logic iv, input logic [2:0] a,
                       input logic [7:0] d, input logic [7:0] rdy);
        logic       ex_ir, do_pop, do_push;
        logic [7:0] ex_ov, ex_od, one;
        word_t      w;
        apply(ncs, iv, a, d, rdy);
        @(negedge clk);
        one   = 8'h01;
        ex_ir = !ncs && (q.size() < 2);
        ex_ov = 8'h00;
        ex_od = 8'h00;
        if (!ncs && q.size() > 0) begin
            ex_ov = one << q[0].a;
            ex_od = q[0].d;
        end
        chk("in_ready",  32'(in_ready),  32'(ex_ir));
        chk("out_valid", 32'(out_valid), 32'(ex_ov));
        chk("out_data",  32'(out_data),  32'(ex_od));
        chk("drop_cnt",  32'(drop_cnt),  32'(drops));
        do_pop  = (ex_ov != 8'h00) && rdy[q[0].a];
        do_push = iv && ex_ir;
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            w.a = a; w.d = d;
            q.push_back(w);
        end
        if (ncs && iv && drops < 255) drops++;
        @(posedge clk); #1;
    endtask

    initial begin
        apply(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        drops = 0;

        //             ncs   iv    a     d      rdy    ir    ov     od
        tbl[0]  = '{1'b0, 1'b1, 3'd3, 8'hA5, 8'hFF, 1'b1, 8'h00, 8'h00};
        tbl[1]  = '{1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h08, 8'hA5};
        tbl[2]  = '{1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h00};
        tbl[3]  = '{1'b0, 1'b1, 3'd0, 8'h11, 8'h00, 1'b1, 8'h00, 8'h00};
        tbl[4]  = '{1'b0, 1'b1, 3'd7, 8'h77, 8'h00, 1'b1, 8'h01, 8'h11};
        tbl[5]  = '{1'b0, 1'b1, 3'd2, 8'h22, 8'h00, 1'b0, 8'h01, 8'h11};
        tbl[6]  = '{1'b0, 1'b1, 3'd2, 8'h22, 8'h01, 1'b0, 8'h01, 8'h11};
        tbl[7]  = '{1'b0, 1'b1, 3'd2, 8'h22, 8'h00, 1'b1, 8'h80, 8'h77};
        tbl[8]  = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h80, 1'b0, 8'h80, 8'h77};
        tbl[9]  = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h04, 1'b1, 8'h04, 8'h22};
        tbl[10] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00};
        tbl[11] = '{1'b0, 1'b1, 3'd5, 8'h55, 8'hDF, 1'b1, 8'h00, 8'h00};

        repeat (2) @(posedge clk);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].ncs, tbl[i].iv, tbl[i].a, tbl[i].d, tbl[i].rdy);
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].exp_ir));
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            chk($sformatf("tbl%0d_out_data", i),  32'(out_data),  32'(tbl[i].exp_od));
            @(posedge clk); #1;
        end

        // Ready on every channel except the head's must not pop.
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b0, 3'd0, 8'h00, 8'hDF);
            @(negedge clk);
            chk("wrongch_out_valid", 32'(out_valid), 32'h20);
            chk("wrongch_out_data",  32'(out_data),  32'h55);
            @(posedge clk); #1;
        end
        apply(1'b0, 1'b0, 3'd0, 8'h00, 8'h20);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrongch_drained", 32'(out_valid), 32'h0);
        @(posedge clk); #1;

        // Streaming: 16 back-to-back words, all ready.
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 3'(i % 8), 8'(i), 8'hFF);
        repeat (2) cyc(1'b0, 1'b0, 3'd0, 8'h00, 8'hFF);

        // Deselect holds contents and counts offered words.
        do_reset();
        cyc(1'b0, 1'b1, 3'd6, 8'h66, 8'h00);
        repeat (4) cyc(1'b1, 1'b1, 3'd1, 8'hEE, 8'hFF);
        apply(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
        chk("desel_drop_cnt",  32'(drop_cnt),  32'd4);
        chk("reselect_valid",  32'(out_valid), 32'h40);
        chk("reselect_data",   32'(out_data),  32'h66);
        @(posedge clk); #1;
        q.delete();
        q.push_back('{a: 3'd6, d: 8'h66});
        drops = 4;
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 8'h40);
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(7) == 0), 1'($urandom), 3'($urandom),
                8'($urandom), ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom));
        end

        // Drop counter saturation.
        do_reset();
        repeat (300) cyc(1'b1, 1'b1, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
        chk("drop_saturated", 32'(drop_cnt), 32'hFF);
        @(posedge clk); #1;

        // Asynchronous reset while full, between clock edges.
        cyc(1'b0, 1'b1, 3'd1, 8'h31, 8'h00);
        cyc(1'b0, 1'b1, 3'd4, 8'h34, 8'h00);
        apply(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready),  32'h0);
        chk("full_valid",    32'(out_valid), 32'h02);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_out_data",  32'(out_data),  32'h0);
        chk("arst_in_ready",  32'(in_ready),  32'h1);
        chk("arst_drop_cnt",  32'(drop_cnt),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        drops = 0;
        @(posedge clk); #1;
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/demux_8_stream.md
Name: demux_8_stream

Overview:
- 1-to-8 addressed demultiplexer; the distribution side of the 8:1 selector path.
- Accepts one input stream of {addr, data} words and routes each word to one of 8 output channels over valid/ready handshakes.
- Buffers words in a 2-entry FIFO so the input never depends combinationally on downstream ready.
- Active-low chip select gates the block; a saturating counter records words offered while deselected.

Parameters:
- width, 8, data word width in bits.
- cnt_width, 8, width of the dropped-word counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- nCS  input  1  active-low chip select; 1 = block deselected.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the input word this cycle.
- in_addr  input  3  destination channel: 0 = out1 … 7 = out8.
- in_data  input  width  input word.
- out_valid  output  8  one-hot per-channel valid; bit i is channel i.
- out_ready  input  8  per-channel ready.
- out_data  output  width  shared output data bus, valid for the asserted channel.
- drop_cnt  output  cnt_width  count of words offered while nCS=1.

Behaviour:
- Reset (async assert, sync release):
  - FIFO count=0, rd/wr pointers=0, drop_cnt=0.
  - Therefore out_valid=0, out_data=0, in_ready=nCS?0:1.
- Storage: 2-entry FIFO of {addr[2:0], data[width-1:0]}; count ranges 0..2.
- in_ready = !nCS && (count<2). Registered state only; no path from out_ready.
- Push: in_valid && in_ready at the clock edge writes the entry at wr_ptr, advances wr_ptr, count+1.
- Head: the entry at rd_ptr when count>0.
- out_valid[i] = !nCS && count>0 && head.addr==i. At most one bit is set.
- out_data = head.data when any out_valid bit is set, else 0.
- Pop: out_valid[head.addr] && out_ready[head.addr] at the edge advances rd_ptr, count−1. Ready on any non-selected channel is ignored.
- Simultaneous push and pop (count==1): count stays 1, head becomes the new word, order is preserved.
- Simultaneous push and pop (count==0): no pop, because out_valid is 0. Push proceeds; the word appears on out_valid the next cycle.
- Latency: an accepted word is presented no earlier than 1 cycle after acceptance. Throughput is 1 word/cycle sustained while the destination stays ready.
- Full (count==2): in_ready=0 until a pop occurs. The pop edge leaves count=1, and in_ready rises in the following cycle.
- Empty: out_valid=0, out_data=0.
- Deselect (nCS=1):
  - in_ready=0, out_valid=0, out_data=0.
  - No push and no pop; FIFO contents are retained.
  - On return to nCS=0, the head is presented in that same cycle.
- Drop counting: each cycle with nCS=1 && in_valid=1 increments drop_cnt by 1. It saturates at all-ones and never wraps; it is cleared only by rst.
- Pointer wrap: 1-bit pointers toggle 0→1→0. A full FIFO with rd_ptr==wr_ptr is disambiguated by count.
- Reset mid-transfer: all buffered words are discarded and outputs go to reset values immediately.
- No X propagation: out_data is 0, not stale data, whenever no valid is asserted.

Test Plan:
- Reset and basic route: rst=1→0, nCS=0. Push {addr=3, data=8'hA5} with out_ready=8'hFF → next cycle out_valid=8'b0000_1000, out_data=8'hA5; one cycle later out_valid=0.
- Back-pressure/full:
  - Hold out_ready=0 and push words with addr=0 and addr=7 → count=2, in_ready=0, out_valid=8'h01 with the first word; a third word is not accepted.
  - Raise out_ready[0] → pop the first word; out_valid becomes 8'h80.
  - The cycle after the pop, in_ready=1 and the third word is accepted.
- Wrong-channel ready: head addr=5, out_ready=8'b1101_1111 → no pop for 10 cycles and out_valid stays 8'h20.
- Streaming: 16 back-to-back words with addr=i%8 and data=i, all ready=1 → words delivered in order, one per cycle after the first, on the matching channels.
- Deselect:
  - Buffer 1 word, then set nCS=1 for 4 cycles with in_valid=1 → out_valid=0, out_data=0, in_ready=0, drop_cnt=4.
  - Set nCS=0 → the buffered word reappears the same cycle.
- Saturation and async reset:
  - nCS=1, in_valid=1 for 300 cycles → drop_cnt=8'hFF.
  - Assert rst asynchronously between clock edges while the FIFO is full → outputs go to reset values without waiting for a clock edge.
